// File: rtl/mario_sprite_fetch_if.sv
// Bundle of scan, position and ROM-side signals for the Mario sprite fetch pipeline.
// The master side is the VGA/game logic plus sprite ROM; the slave side is the fetch block.
interface mario_sprite_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 3
);
  logic              frame_start;
  logic              pix_valid;
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic [9:0]        mario_x;
  logic [9:0]        mario_y;
  logic              face_left;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic              pix_on;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_valid_o;

  modport master (
    output frame_start, pix_valid, draw_x, draw_y, mario_x, mario_y, face_left, rom_q,
    input  rom_addr, pix_on, pix_idx, pix_valid_o
  );

  modport slave (
    input  frame_start, pix_valid, draw_x, draw_y, mario_x, mario_y, face_left, rom_q,
    output rom_addr, pix_on, pix_idx, pix_valid_o
  );
endinterface

// File: rtl/mario_sprite_fetch.sv
// Sprite ROM address generator and pixel stage: 3-cycle fixed pipeline from scan
// position to palette index, with per-frame position shadowing and horizontal flip.
module mario_sprite_fetch #(
  parameter int SPR_W       = 26,
  parameter int SPR_H       = 32,
  parameter int ADDR_W      = 10,
  parameter int IDX_W       = 3,
  parameter int TRANSPARENT = 0
) (
  input logic                clk,
  input logic                reset,
  mario_sprite_fetch_if.slave bus
);

  logic [9:0]        sx;
  logic [9:0]        sy;
  logic              sflip;
  logic [10:0]       x_end;
  logic [10:0]       y_end;
  logic              in_box;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] addr_next;
  logic              on_p0;
  logic              vld_p0;
  logic              on_p1;
  logic              vld_p1;
  logic              opaque;

  function automatic logic [ADDR_W-1:0] sprite_addr(input logic [ADDR_W-1:0] r,
                                                     input logic [ADDR_W-1:0] c);
    return r * ADDR_W'(SPR_W) + c;
  endfunction

  // Box bounds are 11-bit so a sprite parked near x/y=1023 cannot wrap onto the screen.
  always_comb begin
    x_end     = {1'b0, sx} + 11'(SPR_W);
    y_end     = {1'b0, sy} + 11'(SPR_H);
    in_box    = bus.pix_valid &&
                (bus.draw_x >= sx) && ({1'b0, bus.draw_x} < x_end) &&
                (bus.draw_y >= sy) && ({1'b0, bus.draw_y} < y_end);
    col       = ADDR_W'(bus.draw_x - sx);
    if (sflip)
      col = ADDR_W'(SPR_W - 1) - col;
    row       = ADDR_W'(bus.draw_y - sy);
    addr_next = in_box ? sprite_addr(row, col) : '0;
  end

  // Stage A: shadow load and address issue; a coincident pixel sees the old shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx           <= '0;
      sy           <= '0;
      sflip        <= 1'b0;
      bus.rom_addr <= '0;
      on_p0        <= 1'b0;
      vld_p0       <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        sx    <= bus.mario_x;
        sy    <= bus.mario_y;
        sflip <= bus.face_left;
      end
      bus.rom_addr <= addr_next;
      on_p0        <= in_box;
      vld_p0       <= bus.pix_valid;
    end
  end

  // Stage B: flags wait while the ROM registers its read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      on_p1  <= on_p0;
      vld_p1 <= vld_p0;
    end
  end

  assign opaque = on_p1 && (bus.rom_q != IDX_W'(TRANSPARENT));

  // Stage C: pixel output, index forced to zero when not drawn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.pix_on      <= 1'b0;
      bus.pix_idx     <= '0;
      bus.pix_valid_o <= 1'b0;
    end else begin
      bus.pix_on      <= opaque;
      bus.pix_idx     <= opaque ? bus.rom_q : '0;
      bus.pix_valid_o <= vld_p1;
    end
  end

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Self-checking bench for mario_sprite_fetch: table vectors, hand sequences and a
// scoreboard queue compared against a behavioural model with a registered ROM.
module tb_mario_sprite_fetch;
  localparam int SPR_W = 26;
  localparam int SPR_H = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mario_sprite_fetch_if #(.ADDR_W(10), .IDX_W(3)) bus ();
  mario_sprite_fetch dut (.clk(clk), .reset(reset), .bus(bus));

  logic [2:0] mem [0:1023];
  always_ff @(posedge clk) bus.rom_q <= mem[bus.rom_addr];

  typedef struct {
    logic       on;
    logic [2:0] idx;
    logic       v;
    int         hon;
    int         hidx;
  } exp_t;

  typedef struct {
    logic       fs;
    logic       pv;
    logic [9:0] dx;
    logic [9:0] dy;
    logic [9:0] mx;
    logic [9:0] my;
    logic       fl;
    int         a;
    int         on;
    int         idx;
  } vec_t;

  exp_t outq[$];
  vec_t tbl[13];
  int checks = 0;
  int errors = 0;
  logic [9:0] ssx, ssy;
  logic sflip;
  int max_addr, on_count, bad_on;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input int fs, input int pv, input int dx, input int dy,
                              input int mx, input int my, input int fl,
                              input int a, input int on, input int idx);
    vec_t v;
    v.fs = 1'(fs); v.pv = 1'(pv); v.dx = 10'(dx); v.dy = 10'(dy);
    v.mx = 10'(mx); v.my = 10'(my); v.fl = 1'(fl);
    v.a = a; v.on = on; v.idx = idx;
    return v;
  endfunction

  function automatic void model(input logic pv, input logic [9:0] dx, input logic [9:0] dy,
                                output logic inb, output int addr);
    int col, row;
    inb = pv && (dx >= ssx) && (int'(dx) < int'(ssx) + SPR_W) &&
          (dy >= ssy) && (int'(dy) < int'(ssy) + SPR_H);
    col = int'(dx) - int'(ssx);
    if (sflip) col = SPR_W - 1 - col;
    row = int'(dy) - int'(ssy);
    addr = inb ? row * SPR_W + col : 0;
  endfunction

  // One clock: drive a pixel, push its expectation, then check address and outputs.
  task automatic tick(input logic fs, input logic pv, input logic [9:0] dx, input logic [9:0] dy,
                      input int h_addr, input int h_on, input int h_idx);
    logic inb;
    int addr;
    exp_t e;
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.draw_x      = dx;
    bus.draw_y      = dy;
    model(pv, dx, dy, inb, addr);
    e.v    = pv;
    e.on   = inb && (mem[addr] != 3'd0);
    e.idx  = e.on ? mem[addr] : 3'd0;
    e.hon  = h_on;
    e.hidx = h_idx;
    outq.push_back(e);
    if (fs) begin
      ssx   = bus.mario_x;
      ssy   = bus.mario_y;
      sflip = bus.face_left;
    end
    @(posedge clk);
    #1;
    chk("rom_addr", int'(bus.rom_addr), addr);
    if (h_addr >= 0) chk("rom_addr_vec", int'(bus.rom_addr), h_addr);
    if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
    if (bus.pix_on) on_count++;
    if (bus.pix_on && !bus.pix_valid_o) bad_on++;
    if (outq.size() == 3) begin
      e = outq.pop_front();
      chk("pix_on", int'(bus.pix_on), int'(e.on));
      chk("pix_idx", int'(bus.pix_idx), int'(e.idx));
      chk("pix_valid_o", int'(bus.pix_valid_o), int'(e.v));
      if (e.hon >= 0) chk("pix_on_vec", int'(bus.pix_on), e.hon);
      if (e.hidx >= 0) chk("pix_idx_vec", int'(bus.pix_idx), e.hidx);
    end else begin
      chk("flush_pix_on", int'(bus.pix_on), 0);
      chk("flush_pix_valid_o", int'(bus.pix_valid_o), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_pix_on"}, int'(bus.pix_on), 0);
    chk({tag, "_pix_idx"}, int'(bus.pix_idx), 0);
    chk({tag, "_pix_valid_o"}, int'(bus.pix_valid_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 3'((a % 7) + 1);
    mem[0] = 3'd5;
    mem[1] = 3'd0;

    // addr 831 -> 6, 25 -> 5, 26 -> 6, 24 -> 4 from the (a%7)+1 fill
    tbl[0]  = mk(1, 0, 0,   0,   100, 200, 0, 0,   0, 0);
    tbl[1]  = mk(0, 1, 100, 200, 100, 200, 0, 0,   1, 5);
    tbl[2]  = mk(0, 1, 101, 200, 100, 200, 0, 1,   0, 0);
    tbl[3]  = mk(0, 1, 125, 231, 100, 200, 0, 831, 1, 6);
    tbl[4]  = mk(0, 1, 126, 200, 100, 200, 0, 0,   0, 0);
    tbl[5]  = mk(0, 1, 99,  200, 100, 200, 0, 0,   0, 0);
    tbl[6]  = mk(0, 1, 100, 232, 100, 200, 0, 0,   0, 0);
    tbl[7]  = mk(0, 0, 100, 200, 100, 200, 0, 0,   0, 0);
    tbl[8]  = mk(1, 0, 0,   0,   100, 200, 1, 0,   0, 0);
    tbl[9]  = mk(0, 1, 100, 200, 100, 200, 1, 25,  1, 5);
    tbl[10] = mk(0, 1, 125, 201, 100, 200, 1, 26,  1, 6);
    tbl[11] = mk(0, 1, 125, 200, 100, 200, 1, 0,   1, 5);
    tbl[12] = mk(0, 1, 101, 200, 100, 200, 1, 24,  1, 4);

    reset = 1'b1;
    bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
    bus.draw_x = '0; bus.draw_y = '0;
    bus.mario_x = '0; bus.mario_y = '0; bus.face_left = 1'b0;
    ssx = '0; ssy = '0; sflip = 1'b0;
    max_addr = 0; on_count = 0; bad_on = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // position, flip, latency and transparency vectors
    for (int i = 0; i < 13; i++) begin
      bus.mario_x   = tbl[i].mx;
      bus.mario_y   = tbl[i].my;
      bus.face_left = tbl[i].fl;
      tick(tbl[i].fs, tbl[i].pv, tbl[i].dx, tbl[i].dy, tbl[i].a, tbl[i].on, tbl[i].idx);
    end

    // shadow timing: live position moves mid-frame, footprint follows only after frame_start
    bus.mario_x = 10'd100; bus.mario_y = 10'd200; bus.face_left = 1'b0;
    tick(1'b1, 1'b0, 10'd0, 10'd0, 0, 0, 0);
    bus.mario_x = 10'd300;
    tick(1'b0, 1'b1, 10'd100, 10'd200, 0, 1, 5);
    tick(1'b0, 1'b1, 10'd300, 10'd200, 0, 0, 0);
    tick(1'b1, 1'b1, 10'd100, 10'd200, 0, 1, 5);
    tick(1'b0, 1'b1, 10'd100, 10'd200, 0, 0, 0);
    tick(1'b0, 1'b1, 10'd300, 10'd200, 0, 1, 5);
    tick(1'b0, 1'b1, 10'd301, 10'd200, 1, 0, 0);
    tick(1'b0, 1'b1, 10'd300, 10'd200, 0, 1, 5);
    tick(1'b0, 1'b1, 10'd300, 10'd200, 0, 1, 5);

    // asynchronous reset with opaque pixels in flight
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    outq.delete();
    ssx = '0; ssy = '0; sflip = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 10'd0, 10'd0, 0, 1, 5);

    // bottom-right clip: 10x10 visible corner, one of them transparent
    bus.mario_x = 10'd630; bus.mario_y = 10'd470; bus.face_left = 1'b0;
    tick(1'b1, 1'b0, 10'd0, 10'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 10'd635, 10'd475, 0, 0, 0);
    max_addr = 0; on_count = 0; bad_on = 0;
    for (int y = 460; y < 480; y++) begin
      for (int x = 0; x < 640; x++) tick(1'b0, 1'b1, 10'(x), 10'(y), -1, -1, -1);
      for (int b = 0; b < 4; b++) tick(1'b0, 1'b0, 10'd635, 10'(y), 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 10'd0, 10'd0, 0, 0, 0);
    chk("clip_on_count", on_count, 99);
    chk("clip_on_without_valid", bad_on, 0);
    chk("clip_max_addr_le_831", int'(max_addr <= 831), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
